// File: rtl/prediction_display_ctrl.sv
// Prediction display controller: syncs the NN done level, captures argmax, drives blinking/held 7-seg digits.
// Optional macro PRED_HISTORY_EN enables the three-deep history on hex1..hex3.
module prediction_display_ctrl #(
    parameter int BLINK_HALF    = 12500000,
    parameter int BLINK_TOGGLES = 6
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       done,
    input  logic [3:0] argmax_in,
    input  logic       clear,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3,
    output logic       new_result,
    output logic [7:0] result_count,
    output logic [1:0] state_dbg
);

    localparam int BW = $clog2(BLINK_HALF + 1);
    localparam int TW = $clog2(BLINK_TOGGLES + 1);
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        SHOW_NEW = 2'b01,
        HOLD     = 2'b10
    } state_t;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            4'd10:   s = SEG_DASH;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    state_t          state_r, state_s;
    logic            sync1_r, sync2_r, sync3_r;
    logic [BW-1:0]   blink_r, blink_s;
    logic [TW-1:0]   tog_r, tog_s;
    logic            vis_r, vis_s;
    logic [6:0]      newest_r, newest_s;
    logic [6:0]      hex0_r, hex0_s;
    logic            pulse_r, pulse_s;
    logic [7:0]      count_r, count_s;
    logic            capture_s;
`ifdef PRED_HISTORY_EN
    logic [6:0]      hist1_r, hist2_r, hist3_r;
    logic [6:0]      hist1_s, hist2_s, hist3_s;
`endif

    // Rising edge of the synchronized done level; sync3 only remembers the previous sync2 value.
    assign capture_s = sync2_r & ~sync3_r;

    // Next-state, blink sequencing and history shift; clear takes priority over a capture.
    always_comb begin
        state_s  = state_r;
        blink_s  = blink_r;
        tog_s    = tog_r;
        vis_s    = vis_r;
        newest_s = newest_r;
        count_s  = count_r;
        pulse_s  = 1'b0;
`ifdef PRED_HISTORY_EN
        hist1_s  = hist1_r;
        hist2_s  = hist2_r;
        hist3_s  = hist3_r;
`endif
        if (clear) begin
            state_s  = IDLE;
            blink_s  = '0;
            tog_s    = '0;
            vis_s    = 1'b1;
            newest_s = SEG_BLANK;
            count_s  = 8'd0;
`ifdef PRED_HISTORY_EN
            hist1_s  = SEG_BLANK;
            hist2_s  = SEG_BLANK;
            hist3_s  = SEG_BLANK;
`endif
        end else if (capture_s) begin
            state_s  = SHOW_NEW;
            blink_s  = '0;
            tog_s    = '0;
            vis_s    = 1'b1;
            newest_s = seg_decode(argmax_in);
            count_s  = (count_r == 8'hFF) ? 8'hFF : count_r + 8'd1;
            pulse_s  = 1'b1;
`ifdef PRED_HISTORY_EN
            hist3_s  = hist2_r;
            hist2_s  = hist1_r;
            hist1_s  = newest_r;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    state_s = IDLE;
                end
                SHOW_NEW: begin
                    if (blink_r == BW'(BLINK_HALF - 1)) begin
                        blink_s = '0;
                        if (tog_r == TW'(BLINK_TOGGLES - 1)) begin
                            state_s = HOLD;
                            tog_s   = '0;
                            vis_s   = 1'b1;
                        end else begin
                            tog_s = tog_r + TW'(1);
                            vis_s = ~vis_r;
                        end
                    end else begin
                        blink_s = blink_r + BW'(1);
                    end
                end
                HOLD: begin
                    state_s = HOLD;
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end

        case (state_s)
            IDLE:     hex0_s = SEG_DASH;
            SHOW_NEW: hex0_s = vis_s ? newest_s : SEG_BLANK;
            HOLD:     hex0_s = newest_s;
            default:  hex0_s = SEG_DASH;
        endcase
    end

    // State, synchronizer and display registers.
    always_ff @(posedge CLOCK_50 or posedge resetn) begin
        if (resetn) begin
            state_r  <= IDLE;
            sync1_r  <= 1'b0;
            sync2_r  <= 1'b0;
            sync3_r  <= 1'b0;
            blink_r  <= '0;
            tog_r    <= '0;
            vis_r    <= 1'b1;
            newest_r <= SEG_BLANK;
            hex0_r   <= SEG_DASH;
            pulse_r  <= 1'b0;
            count_r  <= 8'd0;
`ifdef PRED_HISTORY_EN
            hist1_r  <= SEG_BLANK;
            hist2_r  <= SEG_BLANK;
            hist3_r  <= SEG_BLANK;
`endif
        end else begin
            state_r  <= state_s;
            sync1_r  <= done;
            sync2_r  <= sync1_r;
            sync3_r  <= sync2_r;
            blink_r  <= blink_s;
            tog_r    <= tog_s;
            vis_r    <= vis_s;
            newest_r <= newest_s;
            hex0_r   <= hex0_s;
            pulse_r  <= pulse_s;
            count_r  <= count_s;
`ifdef PRED_HISTORY_EN
            hist1_r  <= hist1_s;
            hist2_r  <= hist2_s;
            hist3_r  <= hist3_s;
`endif
        end
    end

    assign hex0         = hex0_r;
    assign new_result   = pulse_r;
    assign result_count = count_r;
    assign state_dbg    = state_r;
`ifdef PRED_HISTORY_EN
    assign hex1 = hist1_r;
    assign hex2 = hist2_r;
    assign hex3 = hist3_r;
`else
    assign hex1 = SEG_BLANK;
    assign hex2 = SEG_BLANK;
    assign hex3 = SEG_BLANK;
`endif

endmodule

// File: doc/prediction_display_ctrl.md
PREDICTION_DISPLAY_CTRL -- requirements
Module: prediction_display_ctrl

Interface
REQ-001 SHALL have parameter BLINK_HALF, default 12500000, CLOCK_50 cycles per blink half-period.
REQ-002 SHALL have parameter BLINK_TOGGLES, default 6, number of hex0 toggles after a new result.
REQ-003 SHALL have port CLOCK_50  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port done  input  1  forward-pass-complete level from the slow-clock neural network domain, asynchronous to CLOCK_50.
REQ-006 SHALL have port argmax_in  input  4  predicted class; stable while done is high.
REQ-007 SHALL have port clear  input  1  synchronous history clear, sampled each cycle.
REQ-008 SHALL have port hex0  output  7  newest prediction, active-low segments.
REQ-009 SHALL have ports hex1, hex2, hex3  output  7 each  1st/2nd/3rd-older predictions, active-low.
REQ-010 SHALL have port new_result  output  1  one-cycle pulse per captured result.
REQ-011 SHALL have port result_count  output  8  number of captured results, saturating.
REQ-012 SHALL have port state_dbg  output  2  current FSM state encoding.

Function
REQ-013 SHALL pass done through a two-flop synchronizer, then rising-edge detect on the second flop output.
REQ-014 SHALL capture argmax_in on the CLOCK_50 edge at which the synchronized rising edge is detected: two edges after the first edge sampling done high (sync1 at k, sync2 at k+1, capture at k+2).
REQ-015 SHALL pulse new_result high for exactly one cycle following the capture edge; hex0 shows the new value in that same cycle.
REQ-016 SHALL treat done held high as a single event; a new capture requires done low for at least two CLOCK_50 edges and then high again.
REQ-017 SHALL decode 0..9 as 40,79,24,30,19,12,02,78,00,10 (hex, bit6..bit0), 10 as 3F (dash), 11..15 as 7F (blank).
REQ-018 SHALL shift history on capture: hex3<=hex2, hex2<=hex1, hex1<=hex0 value, hex0<=new; empty slots display 7F.
REQ-019 SHALL increment result_count on capture, saturating at 255.
REQ-020 SHALL implement FSM IDLE(00), SHOW_NEW(01), HOLD(10).
REQ-021 IDLE: no result since reset/clear; hex0=3F, hex1..hex3=7F; capture -> SHOW_NEW.
REQ-022 SHOW_NEW: hex0 alternates digit/7F every BLINK_HALF cycles, starting with digit visible; after BLINK_TOGGLES toggles -> HOLD with digit steady.
REQ-023 HOLD: hex0 steady; capture -> SHOW_NEW.
REQ-024 Capture in SHOW_NEW SHALL restart the blink counter and toggle count, digit visible.
REQ-025 clear SHALL empty history, zero result_count, force IDLE on the next edge, in any state.
REQ-026 Simultaneous clear and capture: clear wins; the result is dropped; new_result stays low.

Reset
REQ-027 resetn high SHALL immediately force: state IDLE, hex0=3F, hex1..hex3=7F, new_result=0, result_count=0, synchronizer and blink counters 0.
REQ-028 A done edge in flight when reset asserts SHALL be discarded; after release, done already high SHALL be captured once (synchronizer resets to 0).

Configuration
REQ-029 Macro PRED_HISTORY_EN: defined -> hex1..hex3 display the three-deep history per REQ-018.
REQ-030 PRED_HISTORY_EN undefined -> no history registers; hex1..hex3 constant 7F; hex0, FSM, result_count unchanged.

Verification
REQ-031 Reset: resetn high -> hex0=3F, hex1..3=7F, result_count=0, state_dbg=00.
REQ-032 BLINK_HALF=4, BLINK_TOGGLES=6; argmax_in=7, done 0->1 -> new_result pulses once two edges later; hex0=78; blinks 78/7F per 4 cycles; HOLD (10) after 24 cycles with hex0=78.
REQ-033 PRED_HISTORY_EN defined; captures 1,2,3,4 -> hex0=19, hex1=30, hex2=24, hex3=79, result_count=4.
REQ-034 clear and done edge same cycle -> no new_result, result_count=0, state IDLE, hex0=3F.
REQ-035 done held high 1000 cycles -> exactly one capture; argmax_in=10 -> hex0=3F; argmax_in=12 -> hex0=7F.
REQ-036 260 captures -> result_count=255; PRED_HISTORY_EN undefined -> hex1..3 remain 7F throughout.
